bound_flasher_monitor: RTL



---
 rtl/bound_flasher_monitor.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bound_flasher_monitor.sv
// Passive observer for the bound-flasher LED bar. It decodes the thermometer
// code back into a level, tracks the run direction and reversals, records the
// most recent peak and valley, and pulses err on malformed codes or illegal
// level moves. It never drives the bar.
module bound_flasher_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LVL_W = 5,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  input  logic             sample_en,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] turn_cnt,
  output logic [LVL_W-1:0] peak,
  output logic [LVL_W-1:0] valley,
  output logic             seq_done,
  output logic             err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    StUnsync = 2'b00,
    StIdle   = 2'b01,
    StUp     = 2'b10,
    StDown   = 2'b11
  } state_e;

  localparam logic [1:0]   ErrBad   = 2'b01;
  localparam logic [1:0]   ErrStep  = 2'b10;
  localparam logic [1:0]   ErrStall = 2'b11;
  localparam logic [LVL_W:0] One    = {{LVL_W{1'b0}}, 1'b1};

  state_e           state_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] peak_q;
  logic [LVL_W-1:0] valley_q;
  logic [CNT_W-1:0] turn_q;
  logic             seq_done_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic [WIDTH:0]   led_ext;
  logic [WIDTH:0]   led_inc;
  logic             code_ok;
  logic [LVL_W-1:0] lvl_new;
  logic [LVL_W:0]   l_ext;
  logic [LVL_W:0]   p_ext;
  logic             l_inc;
  logic             l_dec;
  logic             l_same;
  logic             l_zero;
  logic             l_one;
  logic             p_zero;
  logic             p_ge2;
  logic [CNT_W-1:0] turn_next;

  // Code check in WIDTH+1 bits so all-ones (full bar) counts as valid.
  assign led_ext = {1'b0, led_in};
  assign led_inc = led_ext + {{WIDTH{1'b0}}, 1'b1};
  assign code_ok = ((led_ext & led_inc) == '0);

  // Popcount of the bar; equals the level whenever the code is valid.
  always_comb begin
    lvl_new = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      lvl_new = lvl_new + LVL_W'(led_in[i]);
    end
  end

  // Level relationships, evaluated one bit wider so P+1 never wraps.
  always_comb begin
    l_ext     = {1'b0, lvl_new};
    p_ext     = {1'b0, level_q};
    l_inc     = (l_ext == p_ext + One);
    l_dec     = (level_q != '0) && (l_ext + One == p_ext);
    l_same    = (lvl_new == level_q);
    l_zero    = (lvl_new == '0);
    l_one     = (lvl_new == LVL_W'(1));
    p_zero    = (level_q == '0);
    p_ge2     = (level_q >= LVL_W'(2));
    turn_next = (&turn_q) ? turn_q : turn_q + CNT_W'(1);
  end

  // Run-state FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StUnsync;
      level_q    <= '0;
      peak_q     <= '0;
      valley_q   <= '0;
      turn_q     <= '0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      if (sample_en) begin
        if (!code_ok) begin
          // Malformed bar: resync, but keep the last good level.
          err_q      <= 1'b1;
          err_code_q <= ErrBad;
          state_q    <= StUnsync;
          turn_q     <= '0;
          peak_q     <= '0;
          valley_q   <= '0;
        end else begin
          unique case (state_q)
            StUnsync: begin
              level_q <= lvl_new;
              if (l_zero) state_q <= StIdle;
            end
            StIdle: begin
              if (l_one) begin
                state_q  <= StUp;
                level_q  <= lvl_new;
                turn_q   <= '0;
                peak_q   <= '0;
                valley_q <= '0;
              end else if (!l_zero) begin
                err_q      <= 1'b1;
                err_code_q <= ErrStep;
                state_q    <= StUnsync;
                level_q    <= lvl_new;
                turn_q     <= '0;
                peak_q     <= '0;
                valley_q   <= '0;
              end
            end
            StUp: begin
              if (l_inc) begin
                level_q <= lvl_new;
              end else if (l_dec) begin
                state_q <= StDown;
                level_q <= lvl_new;
                turn_q  <= turn_next;
                peak_q  <= level_q;
              end else if (l_zero && p_ge2) begin
                state_q    <= StIdle;
                level_q    <= '0;
                seq_done_q <= 1'b1;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= l_same ? ErrStall : ErrStep;
                state_q    <= StUnsync;
                level_q    <= lvl_new;
                turn_q     <= '0;
                peak_q     <= '0;
                valley_q   <= '0;
              end
            end
            StDown: begin
              if (l_dec) begin
                level_q <= lvl_new;
              end else if (l_inc) begin
                state_q  <= StUp;
                level_q  <= lvl_new;
                turn_q   <= turn_next;
                valley_q <= level_q;
              end else if (l_zero && (p_ge2 || p_zero)) begin
                // Second zero after reaching the bottom ends the run.
                state_q    <= StIdle;
                level_q    <= '0;
                seq_done_q <= 1'b1;
              end else begin
                err_q      <= 1'b1;
                err_code_q <= (l_same && !p_zero) ? ErrStall : ErrStep;
                state_q    <= StUnsync;
                level_q    <= lvl_new;
                turn_q     <= '0;
                peak_q     <= '0;
                valley_q   <= '0;
              end
            end
            default: state_q <= StUnsync;
          endcase
        end
      end
    end
  end

  assign level    = level_q;
  assign state    = state_q;
  assign turn_cnt = turn_q;
  assign peak     = peak_q;
  assign valley   = valley_q;
  assign seq_done = seq_done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
